// File: rtl/stopwatch_tick_ctrl.sv
// Stopwatch front-end: synchronizes and debounces the two pushbuttons, runs the
// IDLE/RUN/PAUSE control FSM and divides clk into the one-cycle digit-counter tick.
module stopwatch_tick_ctrl #(
    parameter int TICK_DIV   = 1_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    output logic       tick,
    output logic       cnt_clear,
    output logic       running,
    output logic [1:0] state
);
    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;

    // Button vectors: bit 0 = start/stop, bit 1 = clear
    logic [1:0]       sync_p0;
    logic [1:0]       sync_p1;
    logic [1:0]       deb_lvl;
    logic [1:0]       press;
    logic [DEB_W-1:0] deb_cnt [2];
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       next_state;
    logic             ss_press;
    logic             clr_press;
    logic             tick_nxt;
    logic             clr_nxt;

    // Stage p0/p1: two-flop synchronizer for the raw buttons
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= {btn_clear, btn_start_stop};
            sync_p1 <= sync_p0;
        end
    end

    // Debounce: a level is accepted only after DEB_CYCLES consecutive mismatching
    // cycles; the press pulse is issued together with an accepted 0->1.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_lvl <= '0;
            press   <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync_p1[i] == deb_lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_lvl[i] <= sync_p1[i];
                    deb_cnt[i] <= '0;
                    press[i]   <= sync_p1[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign ss_press  = press[0];
    assign clr_press = press[1];

    // FSM state register; running and the pulse outputs are registered alongside
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            running   <= 1'b0;
            tick      <= 1'b0;
            cnt_clear <= 1'b0;
        end else begin
            state     <= next_state;
            running   <= (next_state == S_RUN);
            tick      <= tick_nxt;
            cnt_clear <= clr_nxt;
        end
    end

    // Clear beats start/stop when idle or paused; in RUN only start/stop matters
    always_comb begin
        next_state = S_IDLE;
        case (state)
            S_IDLE: begin
                if (!clr_press && ss_press) next_state = S_RUN;
                else                        next_state = S_IDLE;
            end
            S_RUN: begin
                next_state = ss_press ? S_PAUSE : S_RUN;
            end
            S_PAUSE: begin
                if (clr_press)     next_state = S_IDLE;
                else if (ss_press) next_state = S_RUN;
                else               next_state = S_PAUSE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        tick_nxt = 1'b0;
        clr_nxt  = 1'b0;
        case (state)
            S_RUN:   tick_nxt = (div_cnt == DIV_LAST);
            S_IDLE:  clr_nxt  = clr_press;
            S_PAUSE: clr_nxt  = clr_press;
            default: begin
                tick_nxt = 1'b0;
                clr_nxt  = 1'b0;
            end
        endcase
    end

    // Prescaler keeps its partial interval across PAUSE so resume stays in phase
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else begin
            case (state)
                S_RUN:   div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
                S_PAUSE: div_cnt <= div_cnt;
                default: div_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_tick_ctrl.sv
// Scoreboard bench for stopwatch_tick_ctrl: a scheduled button script pushes expected
// state changes, ticks and clear pulses; a negedge monitor pops and compares them.
module tb_stopwatch_tick_ctrl;
    localparam int TDIV = 5;
    localparam int DEB  = 4;
    localparam int LAT  = DEB + 3;   // drive cycle -> state change cycle

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_start_stop = 1'b1;
    logic       btn_clear = 1'b1;
    logic       tick;
    logic       cnt_clear;
    logic       running;
    logic [1:0] state;

    typedef struct {
        int         cyc;
        logic [1:0] st;
    } st_ev_t;

    st_ev_t     st_q[$];
    int         tick_q[$];
    int         clr_q[$];
    st_ev_t     ev_pop;
    logic [1:0] exp_state = S_IDLE;
    int         exp_tick;
    int         exp_clr;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    bit         mon_en = 1'b0;

    stopwatch_tick_ctrl #(
        .TICK_DIV   (TDIV),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_start_stop (btn_start_stop),
        .btn_clear      (btn_clear),
        .tick           (tick),
        .cnt_clear      (cnt_clear),
        .running        (running),
        .state          (state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    endtask

    task automatic push_st(input int c, input logic [1:0] s);
        st_ev_t ev;
        ev.cyc = c;
        ev.st  = s;
        st_q.push_back(ev);
    endtask

    // RUN from cycle e (div_cnt=ph there) until state leaves RUN at cycle x
    task automatic run_span(input int e, input int ph, input int x, output int ph_out);
        for (int c = e + 1; c <= x; c++) begin
            if ((c - 1 - e + ph) % TDIV == TDIV - 1) tick_q.push_back(c);
        end
        ph_out = (x - e + ph) % TDIV;
    endtask

    task automatic wait_cyc(input int c);
        if (cyc > c) check_val("sched", cyc, c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_at(input int c, input logic ss, input logic clr, input int hold);
        wait_cyc(c);
        btn_start_stop = ss;
        btn_clear      = clr;
        wait_cyc(c + hold);
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
                ev_pop    = st_q.pop_front();
                exp_state = ev_pop.st;
            end
            check_val("state", int'(state), int'(exp_state));
            check_val("running", int'(running), (exp_state == S_RUN) ? 1 : 0);
            exp_tick = (tick_q.size() > 0 && tick_q[0] == cyc) ? 1 : 0;
            if (exp_tick == 1) void'(tick_q.pop_front());
            check_val("tick", int'(tick), exp_tick);
            exp_clr = (clr_q.size() > 0 && clr_q[0] == cyc) ? 1 : 0;
            if (exp_clr == 1) void'(clr_q.pop_front());
            check_val("cnt_clear", int'(cnt_clear), exp_clr);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int g, s1, e1, p1, x1, s2, e2, c1, p2, x2, s3, e3, p3, x3;
        int b1, i1, s4, e4, p4, x4, c2, i2, c3, s5, e5, z, ph;

        // Reset with both buttons held high: everything stays cleared
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_val("rst_state", int'(state), 0);
            check_val("rst_tick", int'(tick), 0);
            check_val("rst_clear", int'(cnt_clear), 0);
            check_val("rst_running", int'(running), 0);
        end
        @(posedge clk);
        #1;
        reset          = 1'b0;
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;
        mon_en         = 1'b1;

        g  = cyc + 3;            // 2-cycle glitch, must be ignored
        s1 = g + 15;  e1 = s1 + LAT;
        p1 = e1 + 16; x1 = p1 + LAT;   // 23 RUN cycles, pause with div_cnt=3
        s2 = x1 + 20; e2 = s2 + LAT;
        c1 = e2 + 3;             // clear while running: ignored
        p2 = e2 + 20; x2 = p2 + LAT;   // a tick lands exactly on RUN->PAUSE
        s3 = x2 + 20; e3 = s3 + LAT;
        p3 = e3 + 14; x3 = p3 + LAT;   // ss+clr together in RUN
        b1 = x3 + 20; i1 = b1 + LAT;   // ss+clr together in PAUSE
        s4 = i1 + 13; e4 = s4 + LAT;
        p4 = e4 + 14; x4 = p4 + LAT;
        c2 = x4 + 20; i2 = c2 + LAT;   // clear from PAUSE
        c3 = i2 + 20;                  // clear while IDLE
        s5 = i2 + 40; e5 = s5 + LAT;
        z  = e5 + 12;                  // synchronous reset mid-run

        push_st(e1, S_RUN);
        run_span(e1, 0, x1, ph);
        push_st(x1, S_PAUSE);
        push_st(e2, S_RUN);
        run_span(e2, ph, x2, ph);
        push_st(x2, S_PAUSE);
        push_st(e3, S_RUN);
        run_span(e3, ph, x3, ph);
        push_st(x3, S_PAUSE);
        push_st(i1, S_IDLE);
        clr_q.push_back(i1);
        push_st(e4, S_RUN);
        run_span(e4, 0, x4, ph);
        push_st(x4, S_PAUSE);
        push_st(i2, S_IDLE);
        clr_q.push_back(i2);
        clr_q.push_back(c3 + LAT);
        push_st(e5, S_RUN);
        run_span(e5, 0, z, ph);        // reset at edge z+1 suppresses any tick there
        push_st(z + 1, S_IDLE);

        press_at(g,  1'b1, 1'b0, 2);
        press_at(s1, 1'b1, 1'b0, 10);
        press_at(p1, 1'b1, 1'b0, 10);
        press_at(s2, 1'b1, 1'b0, 10);
        press_at(c1, 1'b0, 1'b1, 10);
        press_at(p2, 1'b1, 1'b0, 10);
        press_at(s3, 1'b1, 1'b0, 10);
        press_at(p3, 1'b1, 1'b1, 10);
        press_at(b1, 1'b1, 1'b1, 10);
        press_at(s4, 1'b1, 1'b0, 10);
        press_at(p4, 1'b1, 1'b0, 10);
        press_at(c2, 1'b0, 1'b1, 10);
        press_at(c3, 1'b0, 1'b1, 10);
        press_at(s5, 1'b1, 1'b0, 10);

        wait_cyc(z);
        reset = 1'b1;
        wait_cyc(z + 1);
        reset = 1'b0;

        wait_cyc(z + 25);
        mon_en = 1'b0;
        check_val("st_q_left", st_q.size(), 0);
        check_val("tick_q_left", tick_q.size(), 0);
        check_val("clr_q_left", clr_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
